// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and helpers for the serial adder/subtractor (addsub_serial).
//   state_t   : controller states IDLE / RUN / DONE
//   OP_ADD/SUB: encoding of the op input
//   cnt_width : width of the chunk counter for N chunks (at least 1 bit)
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A single-chunk unit still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : addsub_pkg

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit ripple-carry adder slice, time-multiplexed by
// addsub_serial over all chunks of an operand.
// Ports:
//   x, y      : CHUNK-bit addends (y already inverted for subtraction)
//   ci        : carry into bit 0
//   s         : CHUNK-bit sum
//   co        : carry out of the top bit
//   c_msb_in  : carry into the top bit (overflow detection on the MSB chunk)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co       = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];

endmodule : addsub_chunk

// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed CHUNK bits
// per clock, LSB chunk first, through one shared addsub_chunk slice.
//   add: A + B + cin          cout = final carry
//   sub: A + ~B + ~bin        cout = ~final carry (borrow out)
//   ovf: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid / in_ready      : operand handshake (a, b, op, cin)
//   out_valid / out_ready    : result handshake (result, cout, ovf)
// Optional build macro:
//   ADDSUB_SERIAL_SAT_EN     : clamp result to the signed range on overflow
//                              (ovf and cout still report the raw event)
// -----------------------------------------------------------------------------
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(N);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("addsub_serial: WIDTH must be a multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [CHUNK-1:0]   w_x;
    logic [CHUNK-1:0]   w_y_raw;
    logic [CHUNK-1:0]   w_y;
    logic [CHUNK-1:0]   w_s;
    logic               w_co;
    logic               w_c_msb_in;
    logic               w_ovf_now;
    logic [WIDTH-1:0]   w_result_next;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign w_ovf_now = w_co ^ w_c_msb_in;

    // Chunk selection by constant-index compare keeps every slice static.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_x     = '0;
        w_y_raw = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_x     = r_a[i*CHUNK +: CHUNK];
                w_y_raw = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // Subtraction is addition of the inverted subtrahend; the inverted
    // borrow-in was already folded into the carry seed at acceptance.
    assign w_y = (r_op == OP_SUB) ? ~w_y_raw : w_y_raw;

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x        (w_x),
        .y        (w_y),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    always_comb begin
        w_result_next = r_result;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_result_next[i*CHUNK +: CHUNK] = w_s;
            end
        end
`ifdef ADDSUB_SERIAL_SAT_EN
        // Saturate toward the sign of A: an overflow always has both
        // effective operands sharing A's sign.
        if (w_last && w_ovf_now) begin
            w_result_next = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Controller: state register plus combinational next-state logic.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= (op == OP_SUB) ? ~cin : cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_carry  <= w_co;
            r_result <= w_result_next;
            r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= (r_op == OP_SUB) ? ~w_co : w_co;
                r_ovf  <= w_ovf_now;
            end
        end
    end

endmodule : addsub_serial

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
// Directed, table-driven bench for addsub_serial (WIDTH=16, CHUNK=4, N=4),
// plus hand-written sequences for backpressure and mid-operation reset.
// Expected values follow the ADDSUB_SERIAL_SAT_EN build macro when defined.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
    localparam int NVEC  = 10;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       op;
        logic [15:0] a;
        logic [15:0] b;
        logic       cin;
        logic [15:0] exp_result;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[NVEC];

    addsub_serial #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input string name, input logic o,
                           input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           input logic [15:0] er, input logic ec, input logic eo);
        vecs[idx].name       = name;
        vecs[idx].op         = o;
        vecs[idx].a          = va;
        vecs[idx].b          = vb;
        vecs[idx].cin        = vc;
        vecs[idx].exp_result = er;
        vecs[idx].exp_cout   = ec;
        vecs[idx].exp_ovf    = eo;
    endtask

    // Present operands at a negedge; the following posedge accepts them.
    // Returns the number of posedges from acceptance until out_valid is seen.
    task automatic start_op(input logic o, input logic [15:0] va, input logic [15:0] vb,
                            input logic vc, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        op = o; a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 'x; b = 'x; op = 1'bx; cin = 1'bx;
        check("in_ready_after_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_release", out_valid, 0);
        check("in_ready_after_release", in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [15:0] held_result;
        logic        held_cout;
        logic        held_ovf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 1'b0; cin = 1'b0;

`ifdef ADDSUB_SERIAL_SAT_EN
        set_vec(1, "add_signed_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        set_vec(2, "sub_signed_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(7, "add_neg_ovf",    1'b0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
        set_vec(1, "add_signed_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(2, "sub_signed_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        set_vec(7, "add_neg_ovf",    1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif
        set_vec(0, "sub_borrow",     1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        set_vec(3, "add_wrap",       1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        set_vec(4, "add_plain",      1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        set_vec(5, "sub_equal",      1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        set_vec(6, "sub_neg_one",    1'b1, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        set_vec(8, "add_carry_in",   1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);
        set_vec(9, "sub_small",      1'b1, 16'h000F, 16'h0004, 1'b0, 16'h000B, 1'b0, 1'b0);

        // Reset state
        #12;
        check("reset_in_ready",  in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result",    result, 0);
        check("reset_cout",      cout, 0);
        check("reset_ovf",       ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready while idle must not disturb anything
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_out_ready_in_ready",  in_ready, 1);
        check("idle_out_ready_out_valid", out_valid, 0);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check({vecs[i].name, "_latency"}, lat, N);
            check({vecs[i].name, "_result"},  result, vecs[i].exp_result);
            check({vecs[i].name, "_cout"},    cout, vecs[i].exp_cout);
            check({vecs[i].name, "_ovf"},     ovf, vecs[i].exp_ovf);
            release_result();
        end

        // Backpressure: hold DONE for 5 cycles, pulse in_valid in the middle.
        start_op(1'b0, 16'h1234, 16'h4321, 1'b0, lat);
        check("bp_latency", lat, N);
        held_result = result; held_cout = cout; held_ovf = ovf;
        check("bp_result_initial", held_result, 16'h5555);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                in_valid = 1'b1; op = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready",  in_ready, 0);
            check("bp_result",    result, held_result);
            check("bp_cout",      cout, held_cout);
            check("bp_ovf",       ovf, held_ovf);
        end
        in_valid = 1'b0;
        release_result();
        // Accepted on the very next edge
        start_op(1'b1, 16'h0F0F, 16'h0101, 1'b1, lat);
        check("bp_next_latency", lat, N);
        check("bp_next_result",  result, 16'h0E0D);
        check("bp_next_cout",    cout, 0);
        release_result();

        // Reset mid-operation at cnt == 2
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);   // accept, cnt = 0
        #1;
        in_valid = 1'b0;
        @(posedge clk);   // cnt = 1
        @(posedge clk);   // cnt = 2
        #2;
        check("midop_running", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midop_rst_in_ready",  in_ready, 1);
        check("midop_rst_out_valid", out_valid, 0);
        check("midop_rst_result",    result, 0);
        check("midop_rst_cout",      cout, 0);
        check("midop_rst_ovf",       ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b1, 16'h000F, 16'h0004, 1'b0, lat);
        check("post_rst_latency", lat, N);
        check("post_rst_result",  result, 16'h000B);
        check("post_rst_cout",    cout, 0);
        check("post_rst_ovf",     ovf, 0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_addsub_serial
